// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that steps one full_adder over
// WIDTH cycles, LSB first, with registered sum, carry-out and done.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_nxt;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // New result bit enters at the MSB; written as shifts so WIDTH=1 works.
  assign sum_nxt = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= operand_a;
            b_sr    <= operand_b;
            carry_q <= carry_in;
            cnt     <= '0;
            state   <= S_RUN;
            busy    <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          sum_sr  <= sum_nxt;
          carry_q <= fa_carry;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= sum_nxt;
            carry_out <= fa_carry;
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the serial adder
// at WIDTH 1, 8 and 32 against a plain-arithmetic reference.
module tb_serial_adder_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start = '0;
  logic [2:0]  cin = '0;
  logic [31:0] opa [3];
  logic [31:0] opb [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  cout;
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [31:0] s32;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ncyc = 0;
  int wd [3] = '{1, 8, 32};
  localparam int N = 1000;

  always #5 clock = ~clock;

  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clock(clock), .reset(reset), .start(start[0]),
    .operand_a(opa[0][0:0]), .operand_b(opb[0][0:0]),
    .carry_in(cin[0]), .busy(busy[0]), .done(done[0]),
    .sum(s1), .carry_out(cout[0])
  );
  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clock(clock), .reset(reset), .start(start[1]),
    .operand_a(opa[1][7:0]), .operand_b(opb[1][7:0]),
    .carry_in(cin[1]), .busy(busy[1]), .done(done[1]),
    .sum(s8), .carry_out(cout[1])
  );
  serial_adder_ctrl #(.WIDTH(32)) u_w32 (
    .clock(clock), .reset(reset), .start(start[2]),
    .operand_a(opa[2]), .operand_b(opb[2]),
    .carry_in(cin[2]), .busy(busy[2]), .done(done[2]),
    .sum(s32), .carry_out(cout[2])
  );

  function automatic logic [63:0] result(int k);
    case (k)
      0:       return {62'b0, cout[0], s1};
      1:       return {55'b0, cout[1], s8};
      default: return {31'b0, cout[2], s32};
    endcase
  endfunction

  // {carry_out, sum} is just the integer sum of the masked operands.
  function automatic logic [63:0] model(int w, logic [31:0] a,
                                        logic [31:0] b, logic c);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (64'(a) & m) + (64'(b) & m) + 64'(c);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
    cyc++;
  endtask

  task automatic step(int k);
    if (busy[k]) ncyc++;
    tick;
  endtask

  task automatic launch(int k, logic [31:0] a, logic [31:0] b, logic c);
    opa[k] = a;
    opb[k] = b;
    cin[k] = c;
    start[k] = 1'b1;
    tick;
    start[k] = 1'b0;
    ncyc = 0;
  endtask

  task automatic wait_done(int k);
    int g;
    g = 0;
    while (!done[k] && g < 200) begin
      step(k);
      g++;
    end
  endtask

  task automatic op8(string tag, logic [31:0] a, logic [31:0] b, logic c);
    launch(1, a, b, c);
    wait_done(1);
    chk({tag, "_busy_cycles"}, 64'(ncyc), 64'd8);
    chk({tag, "_done"}, 64'(done[1]), 64'd1);
    chk({tag, "_result"}, result(1), model(8, a, b, c));
    tick;
    chk({tag, "_done_drop"}, 64'(done[1]), 64'd0);
    chk({tag, "_idle"}, 64'(busy[1]), 64'd0);
  endtask

  initial begin
    int nd;
    int t0;
    for (int k = 0; k < 3; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    reset = 1'b1;
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_done", 64'(done[k]), 64'd0);
      chk("rst_result", result(k), 64'd0);
    end
    reset = 1'b0;
    tick;

    op8("basic", 32'h5A, 32'h33, 1'b0);
    op8("ripple1", 32'hFF, 32'h01, 1'b0);
    op8("ripple2", 32'hFF, 32'hFF, 1'b1);

    launch(1, 32'h10, 32'h20, 1'b0);
    step(1);
    step(1);
    opa[1] = 32'hAA;
    opb[1] = 32'hAA;
    start[1] = 1'b1;
    step(1);
    start[1] = 1'b0;
    wait_done(1);
    chk("ign_latency", 64'(ncyc), 64'd8);
    chk("ign_result", result(1), 64'h30);
    nd = 0;
    repeat (12) begin
      tick;
      nd += int'(done[1]);
    end
    chk("ign_one_done", 64'(nd), 64'd0);

    launch(1, 32'h01, 32'h02, 1'b0);
    wait_done(1);
    chk("b2b_first", result(1), 64'h3);
    t0 = cyc;
    launch(1, 32'h80, 32'h80, 1'b0);
    chk("b2b_no_idle", 64'(busy[1]), 64'd1);
    wait_done(1);
    chk("b2b_gap", 64'(cyc - t0), 64'd9);
    chk("b2b_second", result(1), 64'h100);
    tick;

    launch(1, 32'h12, 32'h34, 1'b0);
    step(1);
    step(1);
    step(1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_busy", 64'(busy[1]), 64'd0);
    chk("abort_done", 64'(done[1]), 64'd0);
    chk("abort_result", result(1), 64'd0);
    nd = 0;
    repeat (12) begin
      tick;
      nd += int'(done[1]);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op8("after_abort", 32'h7F, 32'h01, 1'b1);

    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic [63:0] exp;
      int          last;
      last = 0;
      a = $urandom;
      b = $urandom;
      c = 1'($urandom);
      launch(k, a, b, c);
      for (int i = 0; i < N; i++) begin
        exp = model(wd[k], a, b, c);
        wait_done(k);
        chk("sweep_result", result(k), exp);
        if (i > 0) chk("sweep_gap", 64'(cyc - last), 64'(wd[k] + 1));
        last = cyc;
        if (i < N - 1) begin
          a = $urandom;
          b = $urandom;
          c = 1'($urandom);
          launch(k, a, b, c);
        end
      end
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences a single full_adder instance over WIDTH cycles to add two WIDTH-bit operands plus carry-in. It captures operands on a start handshake, shifts them LSB-first through the adder with a registered carry, and presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-bit ripple adder, for arithmetic paths that can tolerate latency.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1..32.

- clock  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- operand_a  input  WIDTH  addend A; sampled on the accepting edge.
- operand_b  input  WIDTH  addend B; sampled on the accepting edge.
- carry_in  input  1  initial carry; sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result register; holds its value until the next completion.
- carry_out  output  1  final carry register; holds with sum.

## Operation
- Datapath:
  - One full_adder instance. Its inputs are a_sr[0], b_sr[0] and carry_q.
  - Registers: shift registers a_sr and b_sr (WIDTH bits each), sum_sr (WIDTH bits), carry_q, bit counter cnt (clog2(WIDTH)+1 bits), result registers sum and carry_out.
- States:
  - IDLE: no operation in progress.
  - RUN: adding one bit per cycle.
  - DONE: result just completed.
- IDLE, start=1:
  - a_sr <= operand_a, b_sr <= operand_b, carry_q <= carry_in, cnt <= 0.
  - Next state RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]} (result enters at the MSB and shifts right).
  - carry_q <= fa_carry.
  - a_sr and b_sr shift right by one, filling with 0.
  - cnt <= cnt+1.
- RUN, cnt==WIDTH-1 on the current edge:
  - sum <= {fa_sum, sum_sr[WIDTH-1:1]}, carry_out <= fa_carry.
  - Next state DONE.
- RUN, start asserted: ignored. No queuing, no effect on the operation in progress.
- DONE:
  - done=1 for this cycle.
  - start=1 behaves exactly like start=1 in IDLE (back-to-back operation, next state RUN).
  - Otherwise next state IDLE.
- Arithmetic: {carry_out, sum} = operand_a + operand_b + carry_in, computed modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle; behaviour is otherwise identical.

## Timing
- Reset (synchronous, high on a rising edge):
  - state=IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - a_sr, b_sr, sum_sr, carry_q and cnt cleared.
  - Reset overrides start on the same edge.
  - Reset during RUN aborts the operation. No done pulse; sum and carry_out read 0.
- busy and done are decoded from registered state only; no combinational path from inputs to outputs.
- Latency, with start accepted at edge E0:
  - busy=1 from E0 through edge E0+WIDTH.
  - done=1 between edges E0+WIDTH and E0+WIDTH+1.
  - sum and carry_out change only at edge E0+WIDTH.
- Throughput: with back-to-back starts, one result per WIDTH+1 cycles.
- Operand inputs may change freely after the accepting edge.

## Test plan
- Basic add, WIDTH=8:
  - Stimulus: start with A=0x5A, B=0x33, cin=0.
  - Response: busy high for 8 cycles, done pulses once, sum=0x8D, carry_out=0.
- Full carry ripple:
  - Stimulus: A=0xFF, B=0x01, cin=0.
  - Response: sum=0x00, carry_out=1.
  - Stimulus: A=0xFF, B=0xFF, cin=1.
  - Response: sum=0xFF, carry_out=1.
- Start ignored while busy:
  - Stimulus: start A=0x10, B=0x20; during RUN cycle 3, pulse start with A=0xAA, B=0xAA.
  - Response: exactly one done pulse, sum=0x30, carry_out=0, result at the original latency.
- Back-to-back:
  - Stimulus: first op A=0x01, B=0x02; start held high in the DONE cycle with A=0x80, B=0x80.
  - Response: first result sum=0x03, carry_out=0. Second done exactly 9 cycles after the first; sum=0x00, carry_out=1. IDLE is never visited between the two ops.
- Reset mid-operation:
  - Stimulus: assert reset for one edge at RUN cycle 4.
  - Response: next cycle busy=0, done=0, sum=0, carry_out=0. No done pulse follows. A subsequent operation completes correctly.
- Randomized sweep:
  - Stimulus: 1000 random operand triples at WIDTH=1, 8 and 32.
  - Response: each result matches A+B+cin; done-to-start spacing is always WIDTH+1 cycles.
